// File: rtl/stripe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stripe_scheduler
// Purpose  : Gathers a serial byte stream into lane groups of 1, 2 or 4
//            bytes and emits each group as one aligned parallel write
//            across lanes 0..3. Partial groups can be flushed, with
//            IDLE_BYTE padding the unfilled lanes.
// Revision : 1.0 - initial release
// ============================================================================
module stripe_scheduler #(
    parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [7:0]  data,
    input  logic [1:0]  lane_mode,
    input  logic        flush,
    output logic [7:0]  data_out0,
    output logic [7:0]  data_out1,
    output logic [7:0]  data_out2,
    output logic [7:0]  data_out3,
    output logic [3:0]  valid_out,
    output logic        pad_out,
    output logic        busy,
    output logic [15:0] group_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;  // no partial data held
    localparam logic [0:0] ST_FILL = 1'b1;  // partial group in the buffer

    localparam logic [2:0] C_N4 = 3'd4;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_nxt;
    logic [2:0]  r_nlanes;
    logic [2:0]  w_n;
    logic [7:0]  r_buf  [0:3];
    logic [7:0]  r_dout [0:3];
    logic [7:0]  w_lane [0:3];
    logic [3:0]  w_mask;
    logic [3:0]  r_vout;
    logic        r_pad;
    logic [15:0] r_gcnt;
    logic        w_last;
    logic        w_emit_full;
    logic        w_emit_pad;
    logic        w_emit;

    // Next-state, lane assembly and emission decision for the current cycle
    always_comb begin
        w_n         = r_nlanes;
        w_last      = 1'b0;
        w_emit_full = 1'b0;
        w_emit_pad  = 1'b0;
        w_emit      = 1'b0;
        w_mask      = 4'b1111;
        w_ptr_nxt   = r_ptr;
        w_state_nxt = r_state;
        for (int k = 0; k < 4; k++) begin
            w_lane[k] = IDLE_BYTE;
        end

        // In IDLE the group size follows lane_mode live, so the first byte
        // of a group is already sized by the mode sampled with it.
        if (r_state == ST_IDLE) begin
            case (lane_mode)
                2'b00:   w_n = 3'd1;
                2'b01:   w_n = 3'd2;
                default: w_n = C_N4;
            endcase
        end

        case (w_n)
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase

        w_last      = ({1'b0, r_ptr} == (w_n - 3'd1));
        w_emit_full = valid && w_last;
        // A flush pads whatever is pending, including a byte arriving now
        // that does not itself complete the group.
        w_emit_pad  = flush && !w_emit_full && ((r_state == ST_FILL) || valid);
        w_emit      = w_emit_full || w_emit_pad;

        // Lanes below ptr come from the buffer, lane ptr takes the incoming
        // byte, everything else (unfilled or inactive) is padded.
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_n) begin
                if (2'(k) < r_ptr) begin
                    w_lane[k] = r_buf[k];
                end else if ((2'(k) == r_ptr) && valid) begin
                    w_lane[k] = data;
                end
            end
        end

        if (w_emit) begin
            w_ptr_nxt = 2'd0;
        end else if (valid) begin
            w_ptr_nxt = r_ptr + 2'd1;
        end
        w_state_nxt = (w_ptr_nxt != 2'd0) ? ST_FILL : ST_IDLE;
    end

    // State, gather buffer, registered outputs and group counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_nlanes <= C_N4;
            r_vout   <= 4'b0000;
            r_pad    <= 1'b0;
            r_gcnt   <= 16'd0;
            for (int k = 0; k < 4; k++) begin
                r_buf[k]  <= 8'h00;
                r_dout[k] <= 8'h00;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_nlanes <= w_n;
            if (valid && !w_emit) begin
                r_buf[r_ptr] <= data;
            end
            if (w_emit) begin
                for (int k = 0; k < 4; k++) begin
                    r_dout[k] <= w_lane[k];
                end
                r_vout <= w_mask;
                r_pad  <= w_emit_pad;
                r_gcnt <= r_gcnt + 16'd1;
            end else begin
                r_vout <= 4'b0000;
                r_pad  <= 1'b0;
            end
        end
    end

    assign data_out0 = r_dout[0];
    assign data_out1 = r_dout[1];
    assign data_out2 = r_dout[2];
    assign data_out3 = r_dout[3];
    assign valid_out = r_vout;
    assign pad_out   = r_pad;
    assign busy      = (r_ptr != 2'd0);
    assign group_cnt = r_gcnt;

endmodule
`default_nettype wire

// File: tb/tb_stripe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_stripe_scheduler
// Purpose  : Directed self-checking bench for stripe_scheduler with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stripe_scheduler;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [7:0]  data;
    logic [1:0]  lane_mode;
    logic        flush;
    logic [7:0]  data_out0;
    logic [7:0]  data_out1;
    logic [7:0]  data_out2;
    logic [7:0]  data_out3;
    logic [3:0]  valid_out;
    logic        pad_out;
    logic        busy;
    logic [15:0] group_cnt;

    int n_cmp;
    int n_err;

    stripe_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .data      (data),
        .lane_mode (lane_mode),
        .flush     (flush),
        .data_out0 (data_out0),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .data_out3 (data_out3),
        .valid_out (valid_out),
        .pad_out   (pad_out),
        .busy      (busy),
        .group_cnt (group_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample #1 after the edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] m, input logic f);
        valid     = v;
        data      = d;
        lane_mode = m;
        flush     = f;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_emit(input string tag, input logic [3:0] vo, input logic [31:0] lanes,
                              input logic pad, input logic [15:0] cnt);
        check({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
        check({tag, ".lanes"}, {data_out0, data_out1, data_out2, data_out3}, lanes);
        check({tag, ".pad_out"}, 32'(pad_out), 32'(pad));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".group_cnt"}, 32'(group_cnt), 32'(cnt));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        valid     = 1'b0;
        data      = 8'h00;
        lane_mode = 2'b10;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 8'h00, 2'b10, 1'b0);
        check("rst.lanes", {data_out0, data_out1, data_out2, data_out3}, 32'h0000_0000);
        check("rst.valid_out", 32'(valid_out), 32'd0);
        check("rst.pad_out", 32'(pad_out), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.group_cnt", 32'(group_cnt), 32'd0);

        // Full 4-lane group
        cyc(1'b1, 8'h01, 2'b10, 1'b0);
        check("g4.busy1", 32'(busy), 32'd1);
        check("g4.vo1", 32'(valid_out), 32'd0);
        cyc(1'b1, 8'h02, 2'b10, 1'b0);
        cyc(1'b1, 8'h04, 2'b10, 1'b0);
        cyc(1'b1, 8'h08, 2'b10, 1'b0);
        check_emit("g4", 4'b1111, 32'h01020408, 1'b0, 16'd1);
        cyc(1'b0, 8'h00, 2'b10, 1'b0);
        check("g4.pulse_end", 32'(valid_out), 32'd0);
        check("g4.hold", {data_out0, data_out1, data_out2, data_out3}, 32'h01020408);

        // Two back-to-back 2-lane groups
        cyc(1'b1, 8'h10, 2'b01, 1'b0);
        cyc(1'b1, 8'h20, 2'b01, 1'b0);
        check_emit("g2a", 4'b0011, 32'h1020BCBC, 1'b0, 16'd2);
        cyc(1'b1, 8'h30, 2'b01, 1'b0);
        check("g2b.vo_gap", 32'(valid_out), 32'd0);
        cyc(1'b1, 8'h40, 2'b01, 1'b0);
        check_emit("g2b", 4'b0011, 32'h3040BCBC, 1'b0, 16'd3);

        // Flush of a partial 4-lane group
        cyc(1'b1, 8'hA1, 2'b10, 1'b0);
        cyc(1'b1, 8'hA2, 2'b10, 1'b0);
        check("fl.busy", 32'(busy), 32'd1);
        cyc(1'b0, 8'h00, 2'b10, 1'b1);
        check_emit("fl", 4'b1111, 32'hA1A2BCBC, 1'b1, 16'd4);

        // Mode change mid-group is ignored until the group completes
        cyc(1'b1, 8'h11, 2'b10, 1'b0);
        cyc(1'b1, 8'h22, 2'b00, 1'b0);
        check("mc.vo_mid", 32'(valid_out), 32'd0);
        cyc(1'b1, 8'h33, 2'b00, 1'b0);
        cyc(1'b1, 8'h44, 2'b00, 1'b0);
        check_emit("mc.g4", 4'b1111, 32'h11223344, 1'b0, 16'd5);
        cyc(1'b1, 8'h55, 2'b00, 1'b0);
        check_emit("mc.g1", 4'b0001, 32'h55BCBCBC, 1'b0, 16'd6);
        cyc(1'b1, 8'h56, 2'b00, 1'b0);
        check_emit("mc.g1b", 4'b0001, 32'h56BCBCBC, 1'b0, 16'd7);

        // Flush in IDLE without data has no effect
        cyc(1'b0, 8'h00, 2'b01, 1'b1);
        check("fi.vo", 32'(valid_out), 32'd0);
        check("fi.cnt", 32'(group_cnt), 32'd7);

        // Flush in IDLE with a byte in 2-lane mode pads a single byte
        cyc(1'b1, 8'h81, 2'b01, 1'b1);
        check_emit("fv", 4'b0011, 32'h81BCBCBC, 1'b1, 16'd8);

        // Flush together with a completing byte is a normal emission
        cyc(1'b1, 8'h91, 2'b01, 1'b0);
        cyc(1'b1, 8'h92, 2'b01, 1'b1);
        check_emit("fc", 4'b0011, 32'h9192BCBC, 1'b0, 16'd9);

        // Flush together with a non-completing byte in FILL pads it in
        cyc(1'b1, 8'hB1, 2'b11, 1'b0);
        cyc(1'b1, 8'hB2, 2'b11, 1'b1);
        check_emit("fp", 4'b1111, 32'hB1B2BCBC, 1'b1, 16'd10);

        // Reset mid-group discards partial bytes
        cyc(1'b1, 8'h61, 2'b10, 1'b0);
        cyc(1'b1, 8'h62, 2'b10, 1'b0);
        cyc(1'b1, 8'h63, 2'b10, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 8'h64, 2'b10, 1'b1);
        reset = 1'b0;
        check("rm.vo", 32'(valid_out), 32'd0);
        check("rm.busy", 32'(busy), 32'd0);
        check("rm.cnt", 32'(group_cnt), 32'd0);
        cyc(1'b1, 8'h71, 2'b10, 1'b0);
        cyc(1'b1, 8'h72, 2'b10, 1'b0);
        cyc(1'b1, 8'h73, 2'b10, 1'b0);
        check("rm.vo3", 32'(valid_out), 32'd0);
        cyc(1'b1, 8'h74, 2'b10, 1'b0);
        check_emit("rm.g4", 4'b1111, 32'h71727374, 1'b0, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
